// File: rtl/rsa_result_fifo.sv
// rsa_result_fifo
//
// Result queue between the modular-exponentiation datapath and the readout logic.
// When en and eoc are both high at a rising edge, R_i is pushed. A pop happens when
// rd_valid and rd_ready are both high. When the queue is full, the OVERWRITE parameter
// selects what happens to a push: the new result is dropped, or the oldest entry is
// replaced. Either case sets the sticky overflow flag.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : capture enable (gates pushes only)
//   eoc      : end-of-conversion strobe
//   R_i      : result to capture
//   rd_ready : consumer accepts the head entry
//   clr_ovf  : synchronous clear of overflow (a coincident set wins)
//   C_ex     : head entry, zero when empty
//   rd_valid : queue not empty
//   count    : number of stored entries, 0..DEPTH
//   overflow : sticky drop/overwrite flag
module rsa_result_fifo #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned OVERWRITE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       eoc,
  input  logic [WIDTH-1:0]           R_i,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic [WIDTH-1:0]           C_ex,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam bit OvwEn = (OVERWRITE != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;

  logic push, pop, full, empty;
  logic do_write, rd_inc, ovf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);
  assign push  = en & eoc;
  // An empty queue never pops, so a push/pop pair on empty behaves as a plain push.
  assign pop   = ~empty & rd_ready;

  // A full queue still accepts a push when a pop frees a slot at the same edge.
  // In overwrite mode it always accepts, and the read pointer skips the oldest entry.
  assign do_write = push & (~full | pop | OvwEn);
  assign rd_inc   = pop | (push & full & OvwEn);
  assign ovf_set  = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (do_write) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_inc) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    if (do_write && !rd_inc) begin
      count_d = count_q + CntW'(1);
    end else if (rd_inc && !do_write) begin
      count_d = count_q - CntW'(1);
    end

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; C_ex masks it while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= R_i;
    end
  end

  assign rd_valid = ~empty;
  assign C_ex     = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
